// File: rtl/bram_true_dual_port.sv
// True dual-port block RAM, one clock, write-first on each port, read-before-write across ports.
// Define BRAM_OUT_REG_EN to add a second output register per port (2-cycle read latency).
module bram_true_dual_port #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
    input  logic [RAM_WIDTH-1:0]     data_a_i,
    input  logic                     we_a_i,
    input  logic                     en_a_i,
    output logic [RAM_WIDTH-1:0]     data_a_o,
    input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
    input  logic [RAM_WIDTH-1:0]     data_b_i,
    input  logic                     we_b_i,
    input  logic                     en_b_i,
    output logic [RAM_WIDTH-1:0]     data_b_o
);
    localparam int DEPTH = 1 << RAM_ADDR_BITS;

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                 wr_a;
    logic                 wr_b;
    logic [RAM_WIDTH-1:0] rd_a_p0;
    logic [RAM_WIDTH-1:0] rd_b_p0;

    assign wr_a = rst_i & en_a_i & we_a_i;
    assign wr_b = rst_i & en_b_i & we_b_i;

    // Array write: port A is applied last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        if (wr_b) begin
            mem[addr_b_i] <= data_b_i;
        end
        if (wr_a) begin
            mem[addr_a_i] <= data_a_i;
        end
    end

    // Stage p0: first output register; reads see pre-edge contents of the array.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_a_p0 <= '0;
        end else if (en_a_i) begin
            rd_a_p0 <= we_a_i ? data_a_i : mem[addr_a_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_b_p0 <= '0;
        end else if (en_b_i) begin
            rd_b_p0 <= we_b_i ? data_b_i : mem[addr_b_i];
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic                 vld_a_p0;
    logic                 vld_b_p0;
    logic [RAM_WIDTH-1:0] out_a_p1;
    logic [RAM_WIDTH-1:0] out_b_p1;

    // Stage p1: loads only when the port was enabled on the previous edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
            out_a_p1 <= '0;
            out_b_p1 <= '0;
        end else begin
            vld_a_p0 <= en_a_i;
            vld_b_p0 <= en_b_i;
            if (vld_a_p0) begin
                out_a_p1 <= rd_a_p0;
            end
            if (vld_b_p0) begin
                out_b_p1 <= rd_b_p0;
            end
        end
    end

    assign data_a_o = out_a_p1;
    assign data_b_o = out_b_p1;
`else
    assign data_a_o = rd_a_p0;
    assign data_b_o = rd_b_p0;
`endif

endmodule

// File: tb/tb_bram_true_dual_port.sv
// Bench for bram_true_dual_port: directed vector table, sweep, reset and randomized model-checked traffic.
module tb_bram_true_dual_port;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [9:0] addr_a_i, addr_b_i;
    logic [7:0] data_a_i, data_b_i;
    logic       we_a_i, en_a_i, we_b_i, en_b_i;
    logic [7:0] data_a_o, data_b_o;

    bram_true_dual_port #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .addr_a_i(addr_a_i), .data_a_i(data_a_i), .we_a_i(we_a_i), .en_a_i(en_a_i), .data_a_o(data_a_o),
        .addr_b_i(addr_b_i), .data_b_i(data_b_i), .we_b_i(we_b_i), .en_b_i(en_b_i), .data_b_o(data_b_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents plus what each port should be presenting.
    logic [7:0] mem_m [1024];
    logic [7:0] r_a = 8'h00, r_b = 8'h00;   // value the first register would hold
    logic [7:0] p_a = 8'h00, p_b = 8'h00;   // value the optional second register would hold
    logic       en_pa = 1'b0, en_pb = 1'b0;

    function automatic logic [7:0] exp_a();
        return (LAT == 1) ? r_a : p_a;
    endfunction
    function automatic logic [7:0] exp_b();
        return (LAT == 1) ? r_b : p_b;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        r_a = 8'h00; r_b = 8'h00; p_a = 8'h00; p_b = 8'h00;
        en_pa = 1'b0; en_pb = 1'b0;
    endtask

    // Drive one set of port inputs, take one clock edge, update the model, settle 1 time unit.
    task automatic step(input logic ea, input logic wa, input logic [9:0] aa, input logic [7:0] da,
                        input logic eb, input logic wb, input logic [9:0] ab, input logic [7:0] db);
        logic [7:0] na, nb;
        en_a_i = ea; we_a_i = wa; addr_a_i = aa; data_a_i = da;
        en_b_i = eb; we_b_i = wb; addr_b_i = ab; data_b_i = db;
        @(posedge clk_i);
        if (rst_i) begin
            na = ea ? (wa ? da : mem_m[aa]) : r_a;
            nb = eb ? (wb ? db : mem_m[ab]) : r_b;
            if (en_pa) p_a = r_a;
            if (en_pb) p_b = r_b;
            en_pa = ea;
            en_pb = eb;
            if (eb && wb) mem_m[ab] = db;
            if (ea && wa) mem_m[aa] = da;
            r_a = na;
            r_b = nb;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
    endtask

    // One operation, then enough idle edges for the result to reach the outputs.
    task automatic op(input logic ea, input logic wa, input logic [9:0] aa, input logic [7:0] da,
                      input logic eb, input logic wb, input logic [9:0] ab, input logic [7:0] db);
        step(ea, wa, aa, da, eb, wb, ab, db);
        for (int k = 1; k < LAT; k++) idle();
    endtask

    typedef struct {
        string      nm;
        logic       ea, wa;
        logic [9:0] aa;
        logic [7:0] da;
        logic       eb, wb;
        logic [9:0] ab;
        logic [7:0] db;
        logic [7:0] xa, xb;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input string nm, input logic ea, input logic wa, input logic [9:0] aa,
                                input logic [7:0] da, input logic eb, input logic wb, input logic [9:0] ab,
                                input logic [7:0] db, input logic [7:0] xa, input logic [7:0] xb);
        vec_t v;
        v.nm = nm; v.ea = ea; v.wa = wa; v.aa = aa; v.da = da;
        v.eb = eb; v.wb = wb; v.ab = ab; v.db = db; v.xa = xa; v.xb = xb;
        return v;
    endfunction

    initial begin
        vecs[0] = mk("wr_both_indep", 1, 1, 0,   8'h05, 1, 1, 1,   8'h0A, 8'h05, 8'h0A);
        vecs[1] = mk("rd_cross",      1, 0, 1,   8'h00, 1, 0, 0,   8'h00, 8'h0A, 8'h05);
        vecs[2] = mk("wr_a_3_b_hold", 1, 1, 3,   8'h11, 0, 0, 0,   8'h00, 8'h11, 8'h05);
        vecs[3] = mk("rbw_cross",     1, 1, 3,   8'h22, 1, 0, 3,   8'h00, 8'h22, 8'h11);
        vecs[4] = mk("rd_b_new",      0, 0, 0,   8'h00, 1, 0, 3,   8'h00, 8'h22, 8'h22);
        vecs[5] = mk("collide_wr",    1, 1, 7,   8'h33, 1, 1, 7,   8'h44, 8'h33, 8'h44);
        vecs[6] = mk("collide_rd",    1, 0, 7,   8'h00, 1, 0, 7,   8'h00, 8'h33, 8'h33);
        vecs[7] = mk("rd_b_22",       0, 0, 0,   8'h00, 1, 0, 3,   8'h00, 8'h33, 8'h22);
        vecs[8] = mk("b_dis_we",      0, 0, 0,   8'h00, 0, 1, 0,   8'hFF, 8'h33, 8'h22);
        vecs[9] = mk("mem_unchanged", 1, 0, 0,   8'h00, 0, 0, 0,   8'h00, 8'h05, 8'h22);

        // Reset held with writes requested: outputs stay zero.
        rst_i = 1'b0;
        en_a_i = 1; we_a_i = 1; addr_a_i = 10'd0; data_a_i = 8'hAA;
        en_b_i = 1; we_b_i = 1; addr_b_i = 10'd1; data_b_i = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            chk("rst_hold_a", data_a_o, 8'h00);
            chk("rst_hold_b", data_b_o, 8'h00);
        end
        rst_i = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            op(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].db);
            chk({vecs[i].nm, "_a"}, data_a_o, vecs[i].xa);
            chk({vecs[i].nm, "_b"}, data_b_o, vecs[i].xb);
        end

`ifdef BRAM_OUT_REG_EN
        // Two-cycle latency: nothing new after the first edge, result after the second.
        step(1, 0, 10'd1, 8'h00, 1, 0, 10'd0, 8'h00);
        chk("lat2_early_a", data_a_o, 8'h05);
        chk("lat2_early_b", data_b_o, 8'h22);
        idle();
        chk("lat2_a", data_a_o, 8'h0A);
        chk("lat2_b", data_b_o, 8'h05);
`endif

        // Sweep: A fills low addresses, B fills upper half.
        for (int i = 0; i < 10; i++) begin
            op(1, 1, 10'(i), 8'(5 * (i + 1)), 1, 1, 10'(512 + i), 8'(10 * (i + 1)));
            chk("sweep_wr_a", data_a_o, 8'(5 * (i + 1)));
            chk("sweep_wr_b", data_b_o, 8'(10 * (i + 1)));
        end
        for (int i = 0; i < 10; i++) begin
            op(1, 0, 10'(i), 8'h00, 1, 0, 10'(512 + i), 8'h00);
            chk("sweep_rd_a_lo", data_a_o, 8'(5 * (i + 1)));
            chk("sweep_rd_b_hi", data_b_o, 8'(10 * (i + 1)));
            op(1, 0, 10'(512 + i), 8'h00, 1, 0, 10'(i), 8'h00);
            chk("sweep_rd_a_hi", data_a_o, 8'(10 * (i + 1)));
            chk("sweep_rd_b_lo", data_b_o, 8'(5 * (i + 1)));
        end

        // Mid-run reset: outputs clear before the next edge; writes during reset are dropped.
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async_a", data_a_o, 8'h00);
        chk("rst_async_b", data_b_o, 8'h00);
        model_reset();
        step(1, 1, 10'd0, 8'hAA, 1, 1, 10'd512, 8'hAA);
        chk("rst_mid_a", data_a_o, 8'h00);
        chk("rst_mid_b", data_b_o, 8'h00);
        rst_i = 1'b1;
        op(1, 0, 10'd0, 8'h00, 1, 0, 10'd512, 8'h00);
        chk("rst_blk_wr_a", data_a_o, 8'h05);
        chk("rst_blk_wr_b", data_b_o, 8'h0A);

        // Fill the whole array so random reads never see uninitialised words.
        for (int k = 0; k < 512; k++)
            step(1, 1, 10'(k), 8'($urandom), 1, 1, 10'(512 + k), 8'($urandom));

        // Random traffic over a small address window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 4) != 0, $urandom % 2, 10'($urandom_range(0, 15)), 8'($urandom),
                 ($urandom % 4) != 0, $urandom % 2, 10'($urandom_range(0, 15)), 8'($urandom));
            chk("rand_a", data_a_o, exp_a());
            chk("rand_b", data_b_o, exp_b());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_true_dual_port.md
Name: bram_true_dual_port

Overview:
- True dual-port block RAM: two fully independent ports (A, B), each able to read or write any word on every clock.
- Both ports share one clock and one async active-low reset.
- Used as a shared scratch/frame buffer between two datapath clients; maps onto FPGA BRAM primitives.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_ADDR_BITS, 10, address width; depth = 2**RAM_ADDR_BITS words.

Ports:
- clk_i  in  1  single clock; all port activity on rising edge.
- rst_i  in  1  asynchronous, active-low reset (low = reset asserted).
- addr_a_i  in  RAM_ADDR_BITS  port A word address.
- data_a_i  in  RAM_WIDTH  port A write data.
- we_a_i  in  1  port A write enable (qualified by en_a_i).
- en_a_i  in  1  port A enable; gates both read and write.
- data_a_o  out  RAM_WIDTH  port A registered read data.
- addr_b_i, data_b_i, we_b_i, en_b_i, data_b_o: identical meanings for port B.

Behaviour:
- Reset: rst_i low forces data_a_o = 0 and data_b_o = 0 immediately, without waiting for a clock edge. Memory array contents are not reset and are undefined at power-up.
- While rst_i is low, write accesses are blocked. The first rising edge after rst_i goes high performs normal access.
- Port X disabled (en_X_i = 0): no write; data_X_o holds its previous value.
- Port X read (en = 1, we = 0): data_X_o <= mem[addr_X] on the rising edge. Read latency is 1 cycle.
- Port X write (en = 1, we = 1): mem[addr_X] <= data_X_i on the rising edge. Write-first mode: data_X_o <= data_X_i in the same edge.
- Cross-port read during write, different ports, same address, same edge: the reading port returns the OLD memory content (read-before-write). The new value is visible from the next edge.
- Write collision, both ports, same address, same edge: port A's data is stored. Each port's data_o shows its own data_i (write-first).
- Different addresses: the two ports are fully independent. Simultaneous writes both commit.
- Addresses cover the full 0 .. 2**RAM_ADDR_BITS-1 range; no wrap or out-of-range case exists.
- X-free outputs after reset regardless of memory init.

Optional Feature:
- Macro BRAM_OUT_REG_EN.
- Defined:
  - Adds one output pipeline register per port; read latency becomes 2 cycles.
  - Each pipeline register loads only when its port's en was 1 on the previous edge.
  - Both stages reset to 0 asynchronously.
  - Collision and write-first rules are unchanged; results simply appear one cycle later.
- Undefined: single-register outputs with 1-cycle latency as specified above.

Test Plan:
- Reset: hold rst_i low with en = 1, we = 1, data = 0xAA -> data_a_o = data_b_o = 0x00 throughout. Assert rst_i low mid-run -> outputs return to 0 before the next clock edge.
- Independent write/read:
  - A writes 0x05 @ addr 0; B writes 0x0A @ addr 1 on the same edge. Both data_o show the written values (write-first).
  - Then A reads addr 1 -> 0x0A after 1 cycle; B reads addr 0 -> 0x05 after 1 cycle.
- Sweep: for i = 0..9, A writes 5*(i+1) to addr i and B writes 10*(i+1) to addr 512+i. Read back all 20 words from both ports -> exact values, e.g. addr 9 = 0x32, addr 521 = 0x64.
- Cross-port: mem[3] = 0x11; A writes 0x22 @ 3 while B reads 3 on the same edge -> data_b_o = 0x11. Next B read -> 0x22.
- Collision: A writes 0x33 and B writes 0x44 to addr 7 on the same edge -> data_a_o = 0x33, data_b_o = 0x44. A subsequent read -> 0x33.
- Enable hold: after reading 0x22, drop en_b_i, change addr_b_i and pulse we_b_i with data 0xFF -> data_b_o stays 0x22 and memory is unchanged. With BRAM_OUT_REG_EN defined, repeat the two-port read test -> data appears 2 cycles after the address.
